// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control stage and the counter block's bench.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam int DEB_CYCLES_DEF = 16;
    localparam int TICK_DIV_DEF   = 10;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter-control outputs of the stopwatch control stage.
interface stopwatch_ctrl_if;

    logic BTN_RUN;
    logic BTN_CLR;
    logic CNT_TICK;
    logic CNT_CLR;
    logic RUNNING;

    // slave: the control stage; master: whoever drives the buttons and watches the counter controls
    modport slave  (input BTN_RUN, BTN_CLR, output CNT_TICK, CNT_CLR, RUNNING);
    modport master (output BTN_RUN, BTN_CLR, input CNT_TICK, CNT_CLR, RUNNING);

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Synchroniser + debouncer for one raw button, producing a one-cycle press pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          level_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b00;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            level_d_q <= 1'b0;
            press     <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            // The level only flips after DEB_CYCLES consecutive differing samples.
            if (sync_q[1] != level_q) begin
                if (cnt_q == DEB_MAX) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
            level_d_q <= level_q;
            press     <= level_q & ~level_d_q;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/idle control for the BCD stopwatch counter: debounced buttons in, tick/clear pulses out.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int TICK_DIV   = TICK_DIV_DEF
) (
    input  logic            CLK,
    input  logic            RESET_N,
    stopwatch_ctrl_if.slave sw,
    output sw_state_t       dbg_state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

    logic          run_press;
    logic          clr_press;
    sw_state_t     state_q;
    sw_state_t     state_d;
    logic [PW-1:0] presc_q;
    logic          presc_clr;
    logic          clr_d;
    logic          tick_q;
    logic          clr_q;
    logic          running_q;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .btn_raw (sw.BTN_RUN),
        .press   (run_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .btn_raw (sw.BTN_CLR),
        .press   (clr_press)
    );

    // Clear has priority in IDLE/PAUSE; in RUN only the run button matters.
    always_comb begin
        state_d   = state_q;
        presc_clr = 1'b0;
        clr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_press) begin
                    clr_d = 1'b1;
                end else if (run_press) begin
                    state_d   = RUN;
                    presc_clr = 1'b1;
                end
            end
            RUN: begin
                if (run_press) state_d = PAUSE;
            end
            PAUSE: begin
                if (clr_press) begin
                    state_d   = IDLE;
                    clr_d     = 1'b1;
                    presc_clr = 1'b1;
                end else if (run_press) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            clr_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Prescaler holds outside RUN so a resume keeps the partial period.
            if (presc_clr) begin
                presc_q <= '0;
            end else if (state_q == RUN) begin
                presc_q <= (presc_q == TICK_MAX) ? '0 : presc_q + 1'b1;
            end
            tick_q    <= (state_q == RUN) && (presc_q == TICK_MAX);
            clr_q     <= clr_d;
            running_q <= (state_d == RUN);
        end
    end

    assign sw.CNT_TICK = tick_q;
    assign sw.CNT_CLR  = clr_q;
    assign sw.RUNNING  = running_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEB_CYCLES=4, TICK_DIV=10.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic      CLK;
    logic      RESET_N;
    sw_state_t dbg_state;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(.DEB_CYCLES(4), .TICK_DIV(10)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .sw        (sw_if),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp;
    int n_err;
    int n_tick;
    int n_clr;
    int n_run;

    typedef struct {
        logic        run;
        logic        clr;
        int          cycles;
        logic        tick;
        logic        clr_o;
        logic        running;
        sw_state_t   state;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_tick = 0;
        n_clr  = 0;
        n_run  = 0;
    endtask

    // Advance n cycles, sampling outputs on each falling edge.
    task automatic wait_n(input int n);
        repeat (n) begin
            @(negedge CLK);
            n_tick += int'(sw_if.CNT_TICK);
            n_clr  += int'(sw_if.CNT_CLR);
            n_run  += int'(sw_if.RUNNING);
        end
    endtask

    task automatic set_btn(input logic run, input logic clr);
        sw_if.BTN_RUN = run;
        sw_if.BTN_CLR = clr;
    endtask

    task automatic check_outs(input string name, input logic tick, input logic clr,
                              input logic running, input sw_state_t st);
        check({name, ".tick"},    int'(sw_if.CNT_TICK), int'(tick));
        check({name, ".clr"},     int'(sw_if.CNT_CLR),  int'(clr));
        check({name, ".running"}, int'(sw_if.RUNNING),  int'(running));
        check({name, ".state"},   int'(dbg_state),      int'(st));
    endtask

    // Full press from a quiet debouncer: 8 cycles to the FSM update, then release and settle.
    task automatic press(input logic run, input logic clr);
        set_btn(run, clr);
        wait_n(8);
    endtask

    task automatic release_settle();
        set_btn(1'b0, 1'b0);
        wait_n(10);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_counts();
        set_btn(1'b0, 1'b0);
        RESET_N = 1'b0;

        // run button: glitch, then a 20-cycle hold; ticks at 18 and 28 cycles after the raw edge
        vecs[0] = '{1'b0, 1'b0, 50, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[1] = '{1'b1, 1'b0,  3, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[2] = '{1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[3] = '{1'b1, 1'b0,  7, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[4] = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b1, RUN};
        vecs[5] = '{1'b1, 1'b0,  9, 1'b0, 1'b0, 1'b1, RUN};
        vecs[6] = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b1, RUN};
        vecs[7] = '{1'b1, 1'b0,  2, 1'b0, 1'b0, 1'b1, RUN};
        vecs[8] = '{1'b0, 1'b0,  7, 1'b0, 1'b0, 1'b1, RUN};
        vecs[9] = '{1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b1, RUN};

        wait_n(3);
        check_outs("in_reset", 1'b0, 1'b0, 1'b0, IDLE);
        RESET_N = 1'b1;

        for (int i = 0; i < 10; i++) begin
            set_btn(vecs[i].run, vecs[i].clr);
            wait_n(vecs[i].cycles);
            check_outs($sformatf("vec%0d", i), vecs[i].tick, vecs[i].clr_o,
                       vecs[i].running, vecs[i].state);
        end

        // 300 steady running cycles: one tick every 10th cycle, ending on a tick
        clear_counts();
        wait_n(300);
        check("run300.ticks", n_tick, 30);
        check("run300.end_tick", int'(sw_if.CNT_TICK), 1);

        // pause with prescaler at 6 during the press cycle
        clear_counts();
        wait_n(9);
        set_btn(1'b1, 1'b0);
        wait_n(7);
        check("pause.pre_running", int'(sw_if.RUNNING), 1);
        check("pause.pre_ticks", n_tick, 1);
        wait_n(1);
        check_outs("pause.entered", 1'b0, 1'b0, 1'b0, PAUSE);
        set_btn(1'b0, 1'b0);
        clear_counts();
        wait_n(40);
        check("pause.ticks", n_tick, 0);
        check("pause.running", n_run, 0);

        // resume keeps the fraction: tick 3 cycles after RUNNING rises
        set_btn(1'b1, 1'b0);
        wait_n(7);
        check("resume.pre_running", int'(sw_if.RUNNING), 0);
        wait_n(1);
        check_outs("resume.entered", 1'b0, 1'b0, 1'b1, RUN);
        clear_counts();
        wait_n(2);
        check("resume.early_ticks", n_tick, 0);
        wait_n(1);
        check("resume.first_tick", int'(sw_if.CNT_TICK), 1);
        release_settle();

        // clear is ignored while running
        clear_counts();
        set_btn(1'b0, 1'b1);
        wait_n(12);
        release_settle();
        check("run_clr.pulses", n_clr, 0);
        check("run_clr.state", int'(dbg_state), int'(RUN));

        // PAUSE with run+clear together: clear wins, single CNT_CLR, back to IDLE
        press(1'b1, 1'b0);
        check("pause2.state", int'(dbg_state), int'(PAUSE));
        release_settle();
        clear_counts();
        set_btn(1'b1, 1'b1);
        wait_n(7);
        check("pause_both.pre_clr", int'(sw_if.CNT_CLR), 0);
        wait_n(1);
        check_outs("pause_both", 1'b0, 1'b1, 1'b0, IDLE);
        release_settle();
        check("pause_both.pulses", n_clr, 1);
        check("pause_both.state_after", int'(dbg_state), int'(IDLE));

        // IDLE with run+clear together: clear pulse, stay IDLE
        clear_counts();
        press(1'b1, 1'b1);
        check_outs("idle_both", 1'b0, 1'b1, 1'b0, IDLE);
        release_settle();
        check("idle_both.pulses", n_clr, 1);

        // RUN with run+clear together: run wins, no clear
        press(1'b1, 1'b0);
        check("run_again.state", int'(dbg_state), int'(RUN));
        release_settle();
        clear_counts();
        press(1'b1, 1'b1);
        check_outs("run_both", 1'b0, 1'b0, 1'b0, PAUSE);
        release_settle();
        check("run_both.pulses", n_clr, 0);

        // asynchronous reset mid-RUN with the clear button mid-debounce
        press(1'b1, 1'b0);
        check("pre_reset.running", int'(sw_if.RUNNING), 1);
        release_settle();
        set_btn(1'b0, 1'b1);
        wait_n(3);
        @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        set_btn(1'b0, 1'b0);
        #1;
        check_outs("async_reset", 1'b0, 1'b0, 1'b0, IDLE);
        @(negedge CLK);
        RESET_N = 1'b1;
        set_btn(1'b1, 1'b0);
        clear_counts();
        wait_n(7);
        check("post_reset.pre_running", int'(sw_if.RUNNING), 0);
        wait_n(1);
        check_outs("post_reset.run", 1'b0, 1'b0, 1'b1, RUN);
        check("post_reset.clr_pulses", n_clr, 0);
        release_settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
